// File: rtl/aes_stream_ctrl_pkg.sv
// Shared types and constants for the AES byte-stream controller.
package aes_stream_ctrl_pkg;

  localparam int unsigned AES_BLK_W = 128;
  localparam int unsigned AES_BYTES = 16;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StStart = 2'd1,
    StWait  = 2'd2,
    StDrain = 2'd3
  } state_e;

  // Byte 0 is the most significant byte of the block.
  function automatic logic [7:0] blk_byte(input logic [AES_BLK_W-1:0] blk,
                                          input logic [3:0]           idx);
    logic [6:0] lo;
    lo = {~idx, 3'b000};
    return blk[lo +: 8];
  endfunction

endpackage

// File: rtl/aes_stream_ctrl_if.sv
// Host byte stream, key load and AES core handshake bundle.
interface aes_stream_ctrl_if;
  import aes_stream_ctrl_pkg::*;

  logic                 i_fKeyLoad;
  logic [AES_BLK_W-1:0] i_Key;
  logic                 i_fDec;
  logic                 o_fKeyRdy;
  logic [7:0]           i_InByte;
  logic                 i_fInVld;
  logic                 o_fInRdy;
  logic [7:0]           o_OutByte;
  logic                 o_fOutVld;
  logic                 i_fOutRdy;
  logic                 o_fErr;
  logic                 o_fStart;
  logic                 o_fDec;
  logic [AES_BLK_W-1:0] o_Text;
  logic [AES_BLK_W-1:0] o_Key;
  logic [AES_BLK_W-1:0] i_CoreData;
  logic                 i_fCoreDone;

  modport master (
    input  i_fKeyLoad, i_Key, i_fDec, i_InByte, i_fInVld, i_fOutRdy, i_CoreData, i_fCoreDone,
    output o_fKeyRdy, o_fInRdy, o_OutByte, o_fOutVld, o_fErr, o_fStart, o_fDec, o_Text, o_Key
  );

  modport slave (
    output i_fKeyLoad, i_Key, i_fDec, i_InByte, i_fInVld, i_fOutRdy, i_CoreData, i_fCoreDone,
    input  o_fKeyRdy, o_fInRdy, o_OutByte, o_fOutVld, o_fErr, o_fStart, o_fDec, o_Text, o_Key
  );

endinterface

// File: rtl/aes_byte_serdes.sv
// 128-bit block register with byte shift-in, parallel load and a byte index counter.
module aes_byte_serdes
  import aes_stream_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W = 4
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst,
  input  logic                 i_fClr,
  input  logic                 i_fShift,
  input  logic [7:0]           i_Byte,
  input  logic                 i_fLoad,
  input  logic [AES_BLK_W-1:0] i_Blk,
  input  logic                 i_fAdv,
  output logic [AES_BLK_W-1:0] o_Blk,
  output logic [CNT_W-1:0]     o_Cnt
);

  logic [AES_BLK_W-1:0] r_blk;
  logic [CNT_W-1:0]     r_cnt;

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_blk <= '0;
      r_cnt <= '0;
    end else begin
      if (i_fLoad) begin
        r_blk <= i_Blk;
        r_cnt <= '0;
      end else if (i_fShift) begin
        r_blk <= {r_blk[AES_BLK_W-9:0], i_Byte};
        r_cnt <= r_cnt + CNT_W'(1);
      end else if (i_fAdv) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
      if (i_fClr) begin
        r_cnt <= '0;
      end
    end
  end

  assign o_Blk = r_blk;
  assign o_Cnt = r_cnt;

endmodule

// File: rtl/aes_stream_ctrl.sv
// Host-side initiator for the iterative AES-128 core: gathers 16 bytes, runs the core
// once, and streams the 16 result bytes back out. Key and mode persist across blocks.
module aes_stream_ctrl
  import aes_stream_ctrl_pkg::*;
#(
  parameter int unsigned WAIT_MAX = 63,
  parameter int unsigned CNT_W    = 4
) (
  input logic               i_Clk,
  input logic               i_Rst,
  aes_stream_ctrl_if.master io_Bus
);

  localparam int unsigned WaitW = $clog2(WAIT_MAX + 1);

  state_e               r_state;
  logic [WaitW-1:0]     r_wait;
  logic                 r_fInRdy;
  logic                 r_fKeyRdy;
  logic                 r_fStart;
  logic                 r_fOutVld;
  logic                 r_fErr;
  logic                 r_fDec;
  logic [AES_BLK_W-1:0] r_Key;

  logic                 w_fInAcc;
  logic                 w_fKeyAcc;
  logic                 w_fOutHs;
  logic                 w_fDone;
  logic                 w_fTimeout;
  logic                 w_fInLast;
  logic                 w_fOutLast;
  logic [AES_BLK_W-1:0] w_InBlk;
  logic [AES_BLK_W-1:0] w_OutBlk;
  logic [CNT_W-1:0]     w_InCnt;
  logic [CNT_W-1:0]     w_OutCnt;

  assign w_fInAcc   = io_Bus.i_fInVld & r_fInRdy;
  assign w_fKeyAcc  = io_Bus.i_fKeyLoad & r_fKeyRdy;
  assign w_fOutHs   = r_fOutVld & io_Bus.i_fOutRdy;
  // Core done is only meaningful while a block is outstanding.
  assign w_fDone    = (r_state == StWait) & io_Bus.i_fCoreDone;
  assign w_fTimeout = (r_state == StWait) & ~io_Bus.i_fCoreDone &
                      (r_wait == WaitW'(WAIT_MAX - 1));
  assign w_fInLast  = (w_InCnt == CNT_W'(AES_BYTES - 1));
  assign w_fOutLast = (w_OutCnt == CNT_W'(AES_BYTES - 1));

  aes_byte_serdes #(
    .CNT_W (CNT_W)
  ) u_in_serdes (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_fClr  (w_fTimeout),
    .i_fShift(w_fInAcc),
    .i_Byte  (io_Bus.i_InByte),
    .i_fLoad (1'b0),
    .i_Blk   ('0),
    .i_fAdv  (1'b0),
    .o_Blk   (w_InBlk),
    .o_Cnt   (w_InCnt)
  );

  aes_byte_serdes #(
    .CNT_W (CNT_W)
  ) u_out_serdes (
    .i_Clk   (i_Clk),
    .i_Rst   (i_Rst),
    .i_fClr  (1'b0),
    .i_fShift(1'b0),
    .i_Byte  (8'h00),
    .i_fLoad (w_fDone),
    .i_Blk   (io_Bus.i_CoreData),
    .i_fAdv  (w_fOutHs),
    .o_Blk   (w_OutBlk),
    .o_Cnt   (w_OutCnt)
  );

  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      r_state   <= StFill;
      r_wait    <= '0;
      r_fInRdy  <= 1'b1;
      r_fKeyRdy <= 1'b1;
      r_fStart  <= 1'b0;
      r_fOutVld <= 1'b0;
      r_fErr    <= 1'b0;
      r_fDec    <= 1'b0;
      r_Key     <= '0;
    end else begin
      if (w_fKeyAcc) begin
        r_Key  <= io_Bus.i_Key;
        r_fDec <= io_Bus.i_fDec;
      end
      case (r_state)
        StFill: begin
          if (w_fInAcc) begin
            r_fKeyRdy <= 1'b0;
            if (w_fInLast) begin
              r_state  <= StStart;
              r_fInRdy <= 1'b0;
              r_fStart <= 1'b1;
            end
          end
        end
        StStart: begin
          r_fStart <= 1'b0;
          r_wait   <= '0;
          r_state  <= StWait;
        end
        StWait: begin
          r_wait <= r_wait + WaitW'(1);
          if (w_fDone) begin
            r_state   <= StDrain;
            r_fOutVld <= 1'b1;
          end else if (w_fTimeout) begin
            r_fErr    <= 1'b1;
            r_state   <= StFill;
            r_fInRdy  <= 1'b1;
            r_fKeyRdy <= 1'b1;
          end
        end
        StDrain: begin
          if (w_fOutHs && w_fOutLast) begin
            r_fOutVld <= 1'b0;
            r_state   <= StFill;
            r_fInRdy  <= 1'b1;
            r_fKeyRdy <= 1'b1;
          end
        end
        default: r_state <= StFill;
      endcase
    end
  end

  assign io_Bus.o_fKeyRdy = r_fKeyRdy;
  assign io_Bus.o_fInRdy  = r_fInRdy;
  assign io_Bus.o_OutByte = blk_byte(w_OutBlk, w_OutCnt);
  assign io_Bus.o_fOutVld = r_fOutVld;
  assign io_Bus.o_fErr    = r_fErr;
  assign io_Bus.o_fStart  = r_fStart;
  assign io_Bus.o_fDec    = r_fDec;
  assign io_Bus.o_Text    = w_InBlk;
  assign io_Bus.o_Key     = r_Key;

endmodule

// File: tb/tb_aes_stream_ctrl.sv
// Randomized bench for aes_stream_ctrl with a stand-in AES core and a byte-queue reference model.
module tb_aes_stream_ctrl;
  import aes_stream_ctrl_pkg::*;

  localparam int unsigned WaitMax = 63;
  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_stream_ctrl_if bus ();

  aes_stream_ctrl #(
    .WAIT_MAX (WaitMax),
    .CNT_W    (4)
  ) dut (
    .i_Clk (clk),
    .i_Rst (rst_n),
    .io_Bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model state: bytes of the block being gathered, expected output bytes, key/mode.
  logic [7:0]   in_q[$];
  logic [7:0]   exp_out[$];
  logic [127:0] m_key = '0;
  logic         m_dec = 1'b0;
  logic         m_err = 1'b0;
  bit           m_busy = 1'b0;
  logic [127:0] m_blk_inflight = '0;
  int           m_lat = 0;

  int  cyc = 0;
  int  t_start = 0;
  int  start_cnt = 0;
  int  core_cnt = 0;
  logic [127:0] core_res = '0;
  bit  core_mute = 1'b0;
  bit  core_stale = 1'b0;
  bit  to_active = 1'b0;
  int  to_cnt = 0;
  int  sink_pct = 100;
  bit  bp_force = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in AES core: exact FIPS-197 answers for the reference vector, keyed mixing otherwise.
  function automatic logic [127:0] core_fn(input logic [127:0] t, input logic [127:0] k,
                                           input logic d);
    if (k == FipsKey && !d && t == FipsPt) return FipsCt;
    if (k == FipsKey && d && t == FipsCt) return FipsPt;
    return {t[119:0], t[127:120]} ^ k ^ (d ? {16{8'h5a}} : {16{8'ha5}});
  endfunction

  function automatic logic [127:0] pack_blk(input logic [7:0] q[$]);
    logic [127:0] r;
    r = '0;
    for (int i = 0; i < q.size() && i < 16; i++) r[127-8*i -: 8] = q[i];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Core model and timeout observer.
  initial begin : core_model
    logic st_prev;
    int lat;
    logic [127:0] res;
    st_prev = 1'b0;
    forever begin
      @(negedge clk);
      bus.i_fCoreDone = 1'b0;
      bus.i_CoreData  = rand128();
      if (core_cnt > 0) begin
        core_cnt--;
        if (core_cnt == 0) begin
          bus.i_fCoreDone = 1'b1;
          bus.i_CoreData  = core_res;
          if (core_stale) begin
            core_stale = 1'b0;
          end else begin
            check("text_hold", bus.o_Text, m_blk_inflight);
            check("inrdy_wait", 128'(bus.o_fInRdy), 128'(0));
          end
        end
      end
      if (to_active) begin
        to_cnt++;
        if (to_cnt == WaitMax) check("err_pre_to", 128'(bus.o_fErr), 128'(m_err));
        if (to_cnt == WaitMax + 1) begin
          m_err = 1'b1;
          m_busy = 1'b0;
          check("err_to", 128'(bus.o_fErr), 128'(1));
          check("inrdy_to", 128'(bus.o_fInRdy), 128'(1));
          check("keyrdy_to", 128'(bus.o_fKeyRdy), 128'(1));
          to_active = 1'b0;
        end
      end
      if (rst_n && bus.o_fStart) begin
        check("start_1cyc", 128'(st_prev), 128'(0));
        m_blk_inflight = pack_blk(in_q);
        check("text", bus.o_Text, m_blk_inflight);
        check("key", bus.o_Key, m_key);
        check("dec", 128'(bus.o_fDec), 128'(m_dec));
        check("inrdy_start", 128'(bus.o_fInRdy), 128'(0));
        in_q.delete();
        start_cnt++;
        t_start = cyc;
        if (core_mute) begin
          to_active = 1'b1;
          to_cnt = 0;
        end else begin
          lat = bus.o_fDec ? 23 : int'($urandom_range(4, 12));
          core_cnt = lat;
          core_res = core_fn(bus.o_Text, bus.o_Key, bus.o_fDec);
          m_lat = lat + 1;
          res = core_fn(m_blk_inflight, m_key, m_dec);
          for (int i = 0; i < 16; i++) exp_out.push_back(res[127-8*i -: 8]);
        end
      end
      st_prev = bus.o_fStart;
    end
  end

  // Output sink with random and forced backpressure.
  initial begin : sink
    bit prev_stall, prev_vld, last_hs;
    logic [7:0] prev_byte;
    int out_idx, bp_hold;
    logic rdy;
    prev_stall = 0; prev_vld = 0; last_hs = 0; prev_byte = '0; out_idx = 0; bp_hold = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        bus.i_fOutRdy = 1'b0;
        prev_stall = 0; prev_vld = 0; last_hs = 0; out_idx = 0; bp_hold = 0;
      end else begin
        if (last_hs) check("vld_end", 128'(bus.o_fOutVld), 128'(0));
        last_hs = 0;
        if (bus.o_fOutVld) begin
          if (!prev_vld) check("latency", 128'(cyc - t_start), 128'(m_lat));
          if (prev_stall) check("hold", 128'(bus.o_OutByte), 128'(prev_byte));
          if (bp_force && out_idx == 3 && bp_hold < 5) begin
            rdy = 1'b0;
            bp_hold++;
          end else begin
            rdy = (int'($urandom_range(0, 99)) < sink_pct);
          end
          bus.i_fOutRdy = rdy;
          if (rdy) begin
            if (exp_out.size() == 0) begin
              check("out_extra", 128'(bus.o_fOutVld), 128'(0));
            end else begin
              check("out_byte", 128'(bus.o_OutByte), 128'(exp_out.pop_front()));
            end
            out_idx++;
            if (out_idx == 16) begin
              out_idx = 0;
              bp_hold = 0;
              m_busy = 1'b0;
              last_hs = 1;
            end
          end
          prev_stall = !rdy;
          prev_byte = bus.o_OutByte;
        end else begin
          bus.i_fOutRdy = $urandom_range(0, 1) == 1;
          prev_stall = 0;
        end
        prev_vld = bus.o_fOutVld;
      end
    end
  end

  task automatic load_key(input logic [127:0] k, input logic d);
    bit exp_rdy;
    @(negedge clk);
    bus.i_fKeyLoad = 1'b1;
    bus.i_Key = k;
    bus.i_fDec = d;
    exp_rdy = (in_q.size() == 0) && !m_busy;
    check("keyrdy_load", 128'(bus.o_fKeyRdy), 128'(exp_rdy));
    if (exp_rdy) begin
      m_key = k;
      m_dec = d;
    end
    @(negedge clk);
    bus.i_fKeyLoad = 1'b0;
  endtask

  task automatic send_block(input logic [127:0] data, input int stall_pct, input int kl_idx,
                            input logic [127:0] kl_key, input logic kl_dec);
    int i, guard;
    bit kl_done, exp_rdy;
    i = 0; guard = 0; kl_done = 0;
    while (i < 16 && guard < 2000) begin
      @(negedge clk);
      guard++;
      bus.i_fKeyLoad = 1'b0;
      bus.i_fInVld = (int'($urandom_range(0, 99)) >= stall_pct);
      bus.i_InByte = bus.i_fInVld ? data[127-8*i -: 8] : 8'($urandom);
      if (bus.i_fInVld && i == kl_idx && !kl_done) begin
        kl_done = 1;
        bus.i_fKeyLoad = 1'b1;
        bus.i_Key = kl_key;
        bus.i_fDec = kl_dec;
        exp_rdy = (in_q.size() == 0) && !m_busy;
        check("keyrdy_gate", 128'(bus.o_fKeyRdy), 128'(exp_rdy));
        if (exp_rdy) begin
          m_key = kl_key;
          m_dec = kl_dec;
        end
      end
      if (bus.i_fInVld && bus.o_fInRdy) begin
        in_q.push_back(data[127-8*i -: 8]);
        i++;
        if (in_q.size() == 16) m_busy = 1'b1;
      end
    end
    check("send_done", 128'(i), 128'(16));
    @(negedge clk);
    bus.i_fInVld = 1'b0;
    bus.i_fKeyLoad = 1'b0;
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while ((m_busy || exp_out.size() != 0) && g < 600) begin
      @(negedge clk);
      g++;
    end
    @(negedge clk);
    check("drained", 128'(exp_out.size()), 128'(0));
    check("idle_inrdy", 128'(bus.o_fInRdy), 128'(1));
    check("idle_keyrdy", 128'(bus.o_fKeyRdy), 128'(1));
    check("err", 128'(bus.o_fErr), 128'(m_err));
  endtask

  task automatic wait_start(input int s0);
    int g;
    g = 0;
    while (start_cnt <= s0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check("start_seen", 128'(start_cnt > s0), 128'(1));
  endtask

  task automatic check_reset_outputs();
    check("rst_inrdy", 128'(bus.o_fInRdy), 128'(1));
    check("rst_keyrdy", 128'(bus.o_fKeyRdy), 128'(1));
    check("rst_start", 128'(bus.o_fStart), 128'(0));
    check("rst_outvld", 128'(bus.o_fOutVld), 128'(0));
    check("rst_outbyte", 128'(bus.o_OutByte), 128'(0));
    check("rst_err", 128'(bus.o_fErr), 128'(0));
    check("rst_dec", 128'(bus.o_fDec), 128'(0));
    check("rst_text", bus.o_Text, 128'(0));
    check("rst_key", bus.o_Key, 128'(0));
  endtask

  initial begin : main
    int s0;
    logic [127:0] k2;
    bus.i_fKeyLoad = 1'b0;
    bus.i_Key = '0;
    bus.i_fDec = 1'b0;
    bus.i_InByte = '0;
    bus.i_fInVld = 1'b0;
    bus.i_fOutRdy = 1'b0;
    bus.i_CoreData = '0;
    bus.i_fCoreDone = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // FIPS-197 encrypt and decrypt.
    sink_pct = 100;
    load_key(FipsKey, 1'b0);
    send_block(FipsPt, 0, -1, '0, 1'b0);
    wait_idle();
    load_key(FipsKey, 1'b1);
    send_block(FipsCt, 0, -1, '0, 1'b0);
    wait_idle();

    // Backpressure with forced 5-cycle stall at byte 3 and random input gaps.
    load_key(FipsKey, 1'b0);
    bp_force = 1'b1;
    sink_pct = 50;
    send_block(FipsPt, 40, -1, '0, 1'b0);
    wait_idle();
    for (int b = 0; b < 5; b++) begin
      load_key(rand128(), $urandom_range(0, 1) == 1);
      send_block(rand128(), int'($urandom_range(0, 60)), -1, '0, 1'b0);
      wait_idle();
    end
    bp_force = 1'b0;

    // Key gating: mid-block load ignored, load alongside byte 0 taken.
    load_key(FipsKey, 1'b0);
    k2 = rand128();
    send_block(rand128(), 20, 6, k2, 1'b1);
    wait_idle();
    send_block(rand128(), 0, 0, k2, 1'b1);
    wait_idle();

    // Timeout, then a normal block with the sticky error still set.
    core_mute = 1'b1;
    s0 = start_cnt;
    send_block(rand128(), 10, -1, '0, 1'b0);
    wait_start(s0);
    for (int g = 0; g < 200 && to_active; g++) @(negedge clk);
    check("to_finished", 128'(to_active), 128'(0));
    core_mute = 1'b0;
    wait_idle();
    load_key(FipsKey, 1'b0);
    send_block(FipsPt, 30, -1, '0, 1'b0);
    wait_idle();

    // Reset in the middle of WAIT; the late core done must be ignored.
    load_key(rand128(), 1'b1);
    s0 = start_cnt;
    send_block(rand128(), 0, -1, '0, 1'b0);
    wait_start(s0);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    in_q.delete();
    exp_out.delete();
    m_busy = 1'b0;
    m_key = '0;
    m_dec = 1'b0;
    m_err = 1'b0;
    core_stale = 1'b1;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("post_rst_vld", 128'(bus.o_fOutVld), 128'(0));
    check("post_rst_inrdy", 128'(bus.o_fInRdy), 128'(1));
    check("post_rst_keyrdy", 128'(bus.o_fKeyRdy), 128'(1));

    load_key(FipsKey, 1'b0);
    send_block(FipsPt, 20, -1, '0, 1'b0);
    wait_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
